// File: rtl/fifo_pkg.sv
// Constants shared by my_FIFO users: word width, read latency, burst length,
// and the skid-buffer occupancy encoding.
package fifo_pkg;

  localparam int unsigned DATA_BIT_DEF  = 8;
  localparam int unsigned BURST_LEN_DEF = 8;
  localparam int unsigned FIFO_RD_LAT   = 1;
  // One registered word per cycle of read latency, plus the word on the output.
  localparam int unsigned SKID_DEPTH    = FIFO_RD_LAT + 1;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by the reader.
interface fifo_stream_reader_if #(
  parameter int unsigned DATA_BIT = fifo_pkg::DATA_BIT_DEF,
  parameter int unsigned CNT_BIT  = $clog2(fifo_pkg::BURST_LEN_DEF)
) ();

  logic                fifo_empty;
  logic                fifo_ren;
  logic [DATA_BIT-1:0] fifo_dout;
  logic [DATA_BIT-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic [CNT_BIT-1:0]  beat_cnt;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_ren, m_data, m_valid, m_last, beat_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_ren, m_data, m_valid, m_last, beat_cnt
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry in-order register buffer; entry 0 is always the word presented downstream.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_BIT = DATA_BIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [DATA_BIT-1:0] din,
  input  logic                pop,
  output logic [DATA_BIT-1:0] dout,
  output logic                valid,
  output occ_e                occ
);

  occ_e                occ_q, occ_n;
  logic [DATA_BIT-1:0] e0_q, e0_n, e1_q, e1_n;
  logic                valid_q, valid_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= OCC_0;
      e0_q    <= '0;
      e1_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_n;
      e0_q    <= e0_n;
      e1_q    <= e1_n;
      valid_q <= valid_n;
    end
  end

  // Pop shifts entry 1 forward; push fills the first free slot behind it.
  always_comb begin
    occ_n = occ_q;
    e0_n  = e0_q;
    e1_n  = e1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == OCC_0) begin
          e0_n  = din;
          occ_n = OCC_1;
        end else if (occ_q == OCC_1) begin
          e1_n  = din;
          occ_n = OCC_2;
        end
      end
      2'b01: begin
        e0_n  = e1_q;
        occ_n = (occ_q == OCC_2) ? OCC_1 : OCC_0;
      end
      2'b11: begin
        if (occ_q == OCC_2) begin
          e0_n = e1_q;
          e1_n = din;
        end else begin
          e0_n = din;
        end
      end
      default: ;
    endcase
    valid_n = (occ_n != OCC_0);
  end

  assign dout  = e0_q;
  assign valid = valid_q;
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains my_FIFO through its registered read port and presents the words as a
// valid/ready stream framed into bursts of BURST_LEN beats.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_BIT  = DATA_BIT_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  fifo_stream_reader_if.master  bus
);

  localparam int unsigned        CNT_BIT   = $clog2(BURST_LEN);
  localparam logic [CNT_BIT-1:0] LAST_BEAT = CNT_BIT'(BURST_LEN - 1);

  occ_e               occ;
  logic               infl_q;
  logic               pop_c;
  logic [2:0]         fill_c;
  logic [CNT_BIT-1:0] cnt_q, cnt_n;
  logic               last_q, last_n;

  assign pop_c  = bus.m_valid & bus.m_ready;
  // Words still owned after this edge; a new read must leave room for its landing slot.
  assign fill_c = 3'(occ) + 3'(infl_q) - 3'(pop_c);
  assign bus.fifo_ren = en & ~bus.fifo_empty & (fill_c < 3'(SKID_DEPTH));

  stream_skid_buf #(
    .DATA_BIT (DATA_BIT)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl_q),
    .din   (bus.fifo_dout),
    .pop   (pop_c),
    .dout  (bus.m_data),
    .valid (bus.m_valid),
    .occ   (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= 1'b0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      infl_q <= bus.fifo_ren;
      cnt_q  <= cnt_n;
      last_q <= last_n;
    end
  end

  // Beat position only moves on a delivered word, so EN or stalls freeze it.
  always_comb begin
    cnt_n  = cnt_q;
    last_n = last_q;
    if (pop_c) begin
      cnt_n  = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_BIT'(1);
      last_n = (cnt_n == LAST_BEAT);
    end
  end

  assign bus.beat_cnt = cnt_q;
  assign bus.m_last   = last_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader driven by a small registered-read FIFO model
// (DATA_BIT=8, depth 8) with BURST_LEN=4.
module tb_fifo_stream_reader;

  localparam int unsigned DW    = 8;
  localparam int unsigned BL    = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic ready = 1'b1;
  logic wen   = 1'b0;
  logic [DW-1:0] din = '0;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_BIT(DW), .CNT_BIT(CW)) bus ();

  fifo_stream_reader #(.DATA_BIT(DW), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  // FIFO model: one-cycle registered read, shares the reset
  logic [DW-1:0] fmem [DEPTH];
  logic [2:0]    fwp, frp;
  logic [3:0]    fcnt;
  logic [DW-1:0] fdout;
  logic          frd, fwr;

  assign frd = bus.fifo_ren & (fcnt != 4'd0);
  assign fwr = wen & (fcnt != 4'(DEPTH));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp   <= '0;
      frp   <= '0;
      fcnt  <= '0;
      fdout <= '0;
    end else begin
      if (fwr) begin
        fmem[fwp] <= din;
        fwp       <= fwp + 3'd1;
      end
      if (frd) begin
        fdout <= fmem[frp];
        frp   <= frp + 3'd1;
      end
      fcnt <= fcnt + 4'(fwr) - 4'(frd);
    end
  end

  assign bus.fifo_empty = (fcnt == 4'd0);
  assign bus.fifo_dout  = fdout;
  assign bus.m_ready    = ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Scoreboard and stream monitor, sampled on the falling edge
  logic [DW-1:0] exp_q [$];
  int            exp_beat = 0;
  int            held = 0;
  int            cyc = 0;
  int            pop_total = 0;
  int            pop_cyc [256];
  int            first_ren_cyc = -1;
  int            first_val_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [CW-1:0] prev_beat;
  logic          prev_last;
  logic          mpop;
  logic [DW-1:0] exp_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_beat   = 0;
      held       = 0;
      prev_stall = 1'b0;
    end else begin
      mpop = bus.m_valid & bus.m_ready;
      if (bus.fifo_ren) check("ren_while_empty", 32'(bus.fifo_empty), 32'd0);
      if (held == 2 && !mpop) check("ren_when_full", 32'(bus.fifo_ren), 32'd0);
      if (first_ren_cyc < 0 && bus.fifo_ren) first_ren_cyc = cyc;
      if (first_val_cyc < 0 && bus.m_valid) first_val_cyc = cyc;
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
        check("stall_beat", 32'(bus.beat_cnt), 32'(prev_beat));
        check("stall_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (mpop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(bus.m_data), 32'hFFFF_FFFF);
        end else begin
          exp_d = exp_q.pop_front();
          check("data", 32'(bus.m_data), 32'(exp_d));
        end
        check("beat", 32'(bus.beat_cnt), 32'(exp_beat));
        check("last", 32'(bus.m_last), 32'(exp_beat == int'(BL) - 1));
        pop_cyc[bus.m_data] = cyc;
        pop_total++;
        exp_beat = (exp_beat + 1) % int'(BL);
      end
      held = held + int'(bus.fifo_ren) - int'(mpop);
      if (bus.fifo_ren) check("held_max", 32'(held <= 2), 32'd1);
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_data  = bus.m_data;
      prev_beat  = bus.beat_cnt;
      prev_last  = bus.m_last;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(bus.fifo_ren && bus.fifo_empty))
    else $error("FAIL assert_underflow: ren=1 with empty=1");

  // Caller is positioned 1 time unit after a rising edge.
  task automatic push(input logic [DW-1:0] d);
    wen = 1'b1;
    din = d;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && (exp_q.size() != 0 || bus.m_valid); k++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  int snap, snap2;
  logic pat [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    // 1. reset, async reset mid-operation, then a full-rate stream
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_ren", 32'(bus.fifo_ren), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(bus.m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.m_valid), 32'd0);
    check("async_rst_data", 32'(bus.m_data), 32'd0);
    check("async_rst_last", 32'(bus.m_last), 32'd0);
    check("async_rst_beat", 32'(bus.beat_cnt), 32'd0);
    check("async_rst_ren", 32'(bus.fifo_ren), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    first_ren_cyc = -1;
    first_val_cyc = -1;
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i));
    drain("t1_drain");
    check("t1_latency", 32'(first_val_cyc - first_ren_cyc), 32'd2);
    check("t1_back_to_back", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    // 2. back-pressure with a preloaded FIFO
    en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    check("t2_preload_nonempty", 32'(bus.fifo_empty), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      ready = pat[i % 3];
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    drain("t2_drain");

    // 3. FIFO runs empty mid-burst
    push(8'h20);
    push(8'h21);
    repeat (5) @(posedge clk);
    #1;
    push(8'h22);
    push(8'h23);
    drain("t3_drain");
    check("t3_gap", 32'(pop_cyc[8'h22] - pop_cyc[8'h21] >= 3), 32'd1);

    // 4. EN dropped after two beats of a burst
    en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    snap = pop_total;
    en   = 1'b1;
    for (int i = 0; i < 20 && pop_total < snap + 2; i++) begin
      @(posedge clk);
      #1;
    end
    en    = 1'b0;
    snap2 = pop_total;
    repeat (10) @(posedge clk);
    #1;
    check("t4_tail_le2", 32'(pop_total - snap2 <= 2), 32'd1);
    check("t4_fifo_nonempty", 32'(bus.fifo_empty), 32'd0);
    check("t4_silent", 32'(bus.m_valid), 32'd0);
    check("t4_beat_frozen", 32'(bus.beat_cnt), 32'(exp_beat));
    en = 1'b1;
    drain("t4_drain");
    check("t4_total", 32'(pop_total - snap), 32'd6);

    // 5. FIFO alternating empty / one word
    snap = pop_total;
    for (int i = 0; i < 8; i++) begin
      push(8'h40 + 8'(i));
      repeat (i % 3) @(posedge clk);
      #1;
    end
    drain("t5_drain");
    check("t5_total", 32'(pop_total - snap), 32'd8);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
